// File: rtl/riscv_m_pkg.sv
// Shared RV32M definitions: operand width, funct3 encodings and the FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_m_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // funct3[2] separates the divide group from the multiply group.
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate of a W-bit value (magnitude extraction / sign restore).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: din - value to transform; neg - negate when high; dout - din or -din.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, then sign fix.
// Latency: done in cycle 34 after the start edge (cycle 1 for divide-by-zero / signed overflow).
// Backpressure: busy high while working; start ignored unless idle; flush aborts without done.
// Ports: clk, rst_n (async active-low); start/funct3/op_a/op_b/rd_in request (sampled in IDLE);
//        flush abort; busy, done pulse, result and result_rd all registered.
module muldiv_iter_unit
  import riscv_m_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  result_rd
);

  state_t state, state_nx;
  logic   busy_d, done_d;

  logic [4:0]  cnt;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic [31:0] mag_a_q, mag_b_q;
  logic        sign_a_q, sign_b_q;
  // Multiply: {hi, lo} product accumulator. Divide: low word holds the
  // dividend being shifted out on top and the quotient being shifted in below.
  logic [63:0] acc_q;
  logic [31:0] rem_q;

  // ---------------- request decode ----------------
  logic        sign_a_in, sign_b_in;
  logic [31:0] mag_a_in, mag_b_in;
  logic        div_zero, div_ovf, special;
  logic [31:0] special_res;

  always_comb begin
    sign_a_in = op_a[31] & (funct3 != F3_MULHU) & (funct3 != F3_DIVU) & (funct3 != F3_REMU);
    sign_b_in = op_b[31] & (funct3 != F3_MULHU) & (funct3 != F3_DIVU) & (funct3 != F3_REMU)
                         & (funct3 != F3_MULHSU);
    div_zero  = is_div(funct3) && (op_b == 32'd0);
    div_ovf   = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
    special   = div_zero || div_ovf;
    // funct3[1] picks the remainder flavour within the divide group.
    if (div_zero) special_res = funct3[1] ? op_a : 32'hFFFF_FFFF;
    else          special_res = funct3[1] ? 32'd0 : 32'h8000_0000;
  end

  // 0x80000000 maps onto itself, which is exactly its unsigned magnitude.
  muldiv_sign_fix #(.W(32)) u_mag_a (.din(op_a), .neg(sign_a_in), .dout(mag_a_in));
  muldiv_sign_fix #(.W(32)) u_mag_b (.din(op_b), .neg(sign_b_in), .dout(mag_b_in));

  // ---------------- one iteration ----------------
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift, div_diff;
  logic        div_ge;
  logic [31:0] div_rem_next;

  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_a_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    // 33-bit partial remainder. Since rem < divisor, a non-negative difference
    // always fits in 32 bits, so bit 32 alone flags "divisor did not fit".
    div_shift = {rem_q, acc_q[31]};
    div_diff  = div_shift - {1'b0, mag_b_q};
    div_ge    = ~div_diff[32];
    div_rem_next = div_ge ? div_diff[31:0] : div_shift[31:0];
  end

  // ---------------- sign correction ----------------
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;
  logic [31:0] fix_res;

  muldiv_sign_fix #(.W(64)) u_fix_prod (.din(acc_q), .neg(sign_a_q ^ sign_b_q), .dout(prod_fix));
  muldiv_sign_fix #(.W(32)) u_fix_quot (.din(acc_q[31:0]), .neg(sign_a_q ^ sign_b_q), .dout(quot_fix));
  muldiv_sign_fix #(.W(32)) u_fix_rem  (.din(rem_q), .neg(sign_a_q), .dout(rem_fix));

  always_comb begin
    fix_res = 32'd0;
    case (f3_q)
      F3_MUL:                      fix_res = prod_fix[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_fix[63:32];
      F3_DIV, F3_DIVU:             fix_res = quot_fix;
      default:                     fix_res = rem_fix;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start && !flush) state_nx = special ? DONE : CALC;
      CALC: if (cnt == 5'd0) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush && (state != IDLE)) state_nx = IDLE;
  end

  // busy/done are flopped from the next state so they are clean registers.
  always_comb begin
    busy_d = (state_nx != IDLE);
    done_d = (state_nx == DONE);
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 5'd0;
      f3_q      <= 3'd0;
      rd_q      <= 5'd0;
      mag_a_q   <= 32'd0;
      mag_b_q   <= 32'd0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      acc_q     <= 64'd0;
      rem_q     <= 32'd0;
      result    <= 32'd0;
      result_rd <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !flush) begin
            cnt      <= 5'd31;
            f3_q     <= funct3;
            rd_q     <= rd_in;
            mag_a_q  <= mag_a_in;
            mag_b_q  <= mag_b_in;
            sign_a_q <= sign_a_in;
            sign_b_q <= sign_b_in;
            rem_q    <= 32'd0;
            acc_q    <= is_div(funct3) ? {32'd0, mag_a_in} : {32'd0, mag_b_in};
            if (special) begin
              result    <= special_res;
              result_rd <= rd_in;
            end
          end
        end
        CALC: begin
          if (!flush) begin
            cnt <= cnt - 5'd1;
            if (is_div(f3_q)) begin
              rem_q <= div_rem_next;
              acc_q <= {32'd0, acc_q[30:0], div_ge};
            end else begin
              acc_q <= mul_next;
            end
          end
        end
        FIX: begin
          if (!flush) begin
            result    <= fix_res;
            result_rd <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter_unit.sv
module tb_muldiv_iter_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        flush;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  result_rd;

  muldiv_iter_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .flush(flush),
    .busy(busy), .done(done), .result(result), .result_rd(result_rd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  logic [36:0] sb_q[$];   // {expected result, expected rd}

  always @(posedge clk) if (done === 1'b1) done_count++;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  // Independent reference built on native arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p, ea, eb, ua, ub;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = ea * eb; return p[63:32]; end
      3'b010: begin p = ea * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Drive a request in cycle 0; returns just after the sampling edge (cycle 1).
  task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [31:0] exp, input bit push);
    @(posedge clk); #1;
    funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    if (push) sb_q.push_back({exp, rd});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Watch for done starting at cycle number 'first'; also samples busy one cycle later.
  task automatic collect(input int first, output bit got, output int cyc,
                         output logic [31:0] r, output logic [4:0] rd, output logic busy_after);
    got = 1'b0; cyc = 0; r = '0; rd = '0;
    for (int n = first; n < first + 60 && !got; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1; cyc = n; r = result; rd = result_rd;
      end
    end
    @(negedge clk);
    busy_after = busy;
  endtask

  task automatic run_table(input string tag, input vec_t v[$]);
    bit got; int cyc; logic [31:0] r; logic [4:0] rd; logic ba; logic [36:0] e;
    foreach (v[i]) begin
      send(v[i].f, v[i].a, v[i].b, v[i].rd, v[i].exp, 1'b1);
      collect(1, got, cyc, r, rd, ba);
      e = sb_q.pop_front();
      checks++;
      if (!got) begin errors++; $display("FAIL %s[%0d] timeout: no done within budget", tag, i); end
      checks++;
      if (cyc !== v[i].lat) begin errors++; $display("FAIL %s[%0d] done_cycle got %0d want %0d", tag, i, cyc, v[i].lat); end
      checks++;
      if (r !== e[36:5]) begin errors++; $display("FAIL %s[%0d] result got %h want %h", tag, i, r, e[36:5]); end
      checks++;
      if (rd !== e[4:0]) begin errors++; $display("FAIL %s[%0d] result_rd got %0d want %0d", tag, i, rd, e[4:0]); end
      checks++;
      if (ba !== 1'b0) begin errors++; $display("FAIL %s[%0d] busy_after_done got %b want 0", tag, i, ba); end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if (result_rd !== 5'd0) begin errors++; $display("FAIL reset_result_rd got %0d want 0", result_rd); end
  endtask

  task automatic test_normal_ops;
    vec_t v[$];
    v.push_back('{3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34});
    v.push_back('{3'b001, 32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, 34});
    v.push_back('{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 34});
    v.push_back('{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 34});
    v.push_back('{3'b100, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, 34});
    v.push_back('{3'b110, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, 34});
    v.push_back('{3'b101, 32'd100,        32'd7,         5'd11, 32'd14,        34});
    v.push_back('{3'b111, 32'd100,        32'd7,         5'd12, 32'd2,         34});
    run_table("normal", v);
  endtask

  task automatic test_special;
    vec_t v[$];
    v.push_back('{3'b100, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 1});
    v.push_back('{3'b110, 32'd5,         32'd0,         5'd14, 32'd5,         1});
    v.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1});
    v.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         1});
    v.push_back('{3'b101, 32'd9,         32'd0,         5'd17, 32'hFFFF_FFFF, 1});
    v.push_back('{3'b111, 32'd9,         32'd0,         5'd18, 32'd9,         1});
    run_table("special", v);
  endtask

  task automatic test_random;
    vec_t v[$];
    vec_t x;
    for (int i = 0; i < 16; i++) begin
      x.f  = 3'($urandom_range(0, 7));
      x.a  = $urandom;
      x.b  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if (i == 3) begin x.f = 3'b110; x.a = 32'h8000_0000; x.b = 32'hFFFF_FFFF; end
      x.rd  = 5'($urandom_range(1, 31));
      x.exp = ref_op(x.f, x.a, x.b);
      x.lat = is_special(x.f, x.a, x.b) ? 1 : 34;
      v.push_back(x);
    end
    run_table("random", v);
  endtask

  task automatic test_flush;
    logic [31:0] saved; int dc;
    bit got; int cyc; logic [31:0] r; logic [4:0] rd; logic ba; logic [36:0] e;
    saved = result;
    dc = done_count;
    send(3'b101, 32'd1000, 32'd3, 5'd4, 32'd0, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;                       // cycle 10
    @(posedge clk); #1 flush = 1'b0;       // cycle 11
    funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd21; start = 1'b1;
    sb_q.push_back({32'd14, 5'd21});
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_done got %b want 0", done); end
    checks++; if (result !== saved) begin errors++; $display("FAIL flush_result got %h want %h", result, saved); end
    checks++; if (done_count !== dc) begin errors++; $display("FAIL flush_no_done got %0d want %0d", done_count, dc); end
    @(posedge clk); #1 start = 1'b0;
    collect(1, got, cyc, r, rd, ba);
    e = sb_q.pop_front();
    checks++; if (!got) begin errors++; $display("FAIL flush_restart timeout: no done"); end
    checks++; if (cyc !== 34) begin errors++; $display("FAIL flush_restart_cycle got %0d want 34", cyc); end
    checks++; if (r !== e[36:5]) begin errors++; $display("FAIL flush_restart_result got %h want %h", r, e[36:5]); end
    checks++; if (rd !== e[4:0]) begin errors++; $display("FAIL flush_restart_rd got %0d want %0d", rd, e[4:0]); end
  endtask

  task automatic test_ignored_start;
    int dc;
    bit got; int cyc; logic [31:0] r; logic [4:0] rd; logic ba; logic [36:0] e;
    send(3'b101, 32'd100, 32'd7, 5'd3, 32'd14, 1'b1);
    repeat (4) @(posedge clk);
    #1;                                    // cycle 5
    funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3; rd_in = 5'd9; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;       // cycle 6
    collect(6, got, cyc, r, rd, ba);
    e = sb_q.pop_front();
    checks++; if (!got) begin errors++; $display("FAIL ignored_start timeout: no done"); end
    checks++; if (cyc !== 34) begin errors++; $display("FAIL ignored_start_cycle got %0d want 34", cyc); end
    checks++; if (r !== e[36:5]) begin errors++; $display("FAIL ignored_start_result got %h want %h", r, e[36:5]); end
    checks++; if (rd !== e[4:0]) begin errors++; $display("FAIL ignored_start_rd got %0d want %0d", rd, e[4:0]); end
    dc = done_count;
    repeat (40) @(negedge clk);
    checks++; if (done_count !== dc) begin errors++; $display("FAIL ignored_start_queued got %0d dones want %0d", done_count, dc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignored_start_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    int dc;
    send(3'b000, 32'h1234, 32'h5678, 5'd7, 32'd0, 1'b0);
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0;                       // cycle 20
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b want 0", done); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL rst_mid_result got %h want 0", result); end
    checks++; if (result_rd !== 5'd0) begin errors++; $display("FAIL rst_mid_result_rd got %0d want 0", result_rd); end
    dc = done_count;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (done_count !== dc) begin errors++; $display("FAIL rst_mid_late_done got %0d want %0d", done_count, dc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy_after got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_normal_ops();
    test_special();
    test_random();
    test_flush();
    test_ignored_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
